fifo_srl_flex: RTL

- Next-generation shift-register FIFO for accelerator datapaths.
- Adds over the current SRL FIFO: optional registered output stage, occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and a sticky overflow flag.
- Sits between producer/consumer stages using valid/ready handshakes.

---
 rtl/fifo_pkg.sv | 11 +
 rtl/srl_shift_array.sv | 21 ++
 rtl/fifo_srl_flex.sv | 83 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and default thresholds for the flexible SRL FIFO.
package fifo_pkg;
  localparam int unsigned DEF_AFULL_MARGIN = 2;
  localparam int unsigned DEF_AEMPTY_THRESH = 2;
  function automatic int unsigned fifo_level_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction
  function automatic int unsigned fifo_cap(input int unsigned depth, input int unsigned output_reg);
    return depth + ((output_reg != 0) ? 1 : 0);
  endfunction
endpackage

// File: rtl/srl_shift_array.sv
// srl_shift_array: plain shift storage, new data enters at index 0, indexed read port.
module srl_shift_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = shift_en ? (i == 0 ? wr_data : mem_q[i-1]) : mem_q[i];
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) if (rd_idx == IDX_W'(i)) rd_data = mem_q[i];
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/fifo_srl_flex.sv
// fifo_srl_flex: valid/ready SRL FIFO with optional output register, level, thresholds, flush, sticky overflow.
module fifo_srl_flex import fifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned OUTPUT_REG = 1,
  parameter int unsigned AFULL_THRESH = FIFO_DEPTH - DEF_AFULL_MARGIN,
  parameter int unsigned AEMPTY_THRESH = DEF_AEMPTY_THRESH,
  localparam int unsigned LEVEL_WIDTH = fifo_level_width(FIFO_DEPTH)
) (
  input  logic                   clkIn,
  input  logic                   rstNIn,
  input  logic                   flushIn,
  input  logic                   clrErrIn,
  input  logic [DATA_WIDTH-1:0]  wrDataIn,
  input  logic                   wrValidIn,
  output logic                   wrReadyOut,
  output logic [DATA_WIDTH-1:0]  rdDataOut,
  output logic                   rdValidOut,
  input  logic                   rdReadyIn,
  output logic [LEVEL_WIDTH-1:0] levelOut,
  output logic                   almostFullOut,
  output logic                   almostEmptyOut,
  output logic                   overflowOut
);
  localparam int unsigned CAP = fifo_cap(FIFO_DEPTH, OUTPUT_REG);
  localparam logic OREG = OUTPUT_REG != 0;
  logic [LEVEL_WIDTH-1:0] level_q, level_d, srl_cnt, rd_idx;
  logic [DATA_WIDTH-1:0] out_q, out_d, srl_rd_data;
  logic wr_ready_q, wr_ready_d, rd_valid_q, rd_valid_d;
  logic afull_q, afull_d, aempty_q, aempty_d, ovf_q, ovf_d;
  logic wr_en, rd_en, live, load, bypass, shift_en;
  assign wr_en = wrValidIn & wr_ready_q;
  assign rd_en = rdReadyIn & rd_valid_q;
  assign live = rstNIn & ~flushIn;
  always_comb begin
    level_d = flushIn ? '0 : level_q + LEVEL_WIDTH'(wr_en) - LEVEL_WIDTH'(rd_en);
    wr_ready_d = 32'(level_d) < CAP;
    rd_valid_d = level_d != '0;
    afull_d = 32'(level_d) >= AFULL_THRESH;
    aempty_d = 32'(level_d) <= AEMPTY_THRESH;
    ovf_d = (wrValidIn & ~wr_ready_q & live) | (ovf_q & ~clrErrIn);
    // with an output register, a non-empty FIFO always keeps its head there
    srl_cnt = level_q - LEVEL_WIDTH'(rd_valid_q & OREG);
    rd_idx = srl_cnt - LEVEL_WIDTH'(1);
    load = OREG & (~rd_valid_q | rd_en);
    bypass = load & (srl_cnt == '0);
    shift_en = live & wr_en & ~bypass;
    out_d = load ? (bypass ? (wr_en ? wrDataIn : out_q) : srl_rd_data) : out_q;
  end
  always_ff @(posedge clkIn) begin
    if (!rstNIn) begin
      level_q <= '0;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      afull_q <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q <= 1'b0;
      out_q <= '0;
    end else begin
      level_q <= level_d;
      wr_ready_q <= wr_ready_d;
      rd_valid_q <= rd_valid_d;
      afull_q <= afull_d;
      aempty_q <= aempty_d;
      ovf_q <= ovf_d;
      out_q <= out_d;
    end
  end
  srl_shift_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .IDX_W(LEVEL_WIDTH)) u_srl (
    .clk(clkIn),
    .shift_en(shift_en),
    .wr_data(wrDataIn),
    .rd_idx(rd_idx),
    .rd_data(srl_rd_data)
  );
  assign rdDataOut = OREG ? out_q : srl_rd_data;
  assign wrReadyOut = wr_ready_q;
  assign rdValidOut = rd_valid_q;
  assign levelOut = level_q;
  assign almostFullOut = afull_q;
  assign almostEmptyOut = aempty_q;
  assign overflowOut = ovf_q;
endmodule
